// File: rtl/crt_frame_capture.sv
// Receive side of the CRT pixel stream: rebuilds a WIDTH x HEIGHT frame row by row,
// then drains the rows over valid/ready and reports the frame's lit-pixel count.
module crt_frame_capture #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned HEIGHT = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic                      pix_in,
  output logic                      pix_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_row,
  output logic [$clog2(HEIGHT)-1:0] out_row_idx,
  output logic [CNT_W-1:0]          lit_count,
  output logic                      frame_done,
  output logic                      overflow
);

  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W = $clog2(HEIGHT);

  localparam logic [0:0] StCapture = 1'b0;
  localparam logic [0:0] StDrain   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] lit_q, lit_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] row_buf_q [HEIGHT];

  logic             accept;
  logic             handshake;
  logic             last_col;
  logic             last_row;
  logic             last_rd;
  logic [WIDTH-1:0] row_word;

  always_comb begin
    pix_ready = (state_q == StCapture);
    out_valid = (state_q == StDrain);
    accept    = pix_valid & pix_ready;
    handshake = out_valid & out_ready;
    last_col  = (col_q == COL_W'(WIDTH - 1));
    last_row  = (row_q == ROW_W'(HEIGHT - 1));
    last_rd   = (rd_idx_q == ROW_W'(HEIGHT - 1));
    // Completed row includes the pixel being accepted this cycle.
    row_word  = {shift_q[WIDTH-2:0], pix_in};
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    rd_idx_d     = rd_idx_q;
    shift_d      = shift_q;
    lit_d        = lit_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (pix_valid & ~pix_ready);

    if (accept) begin
      shift_d = row_word;
      lit_d   = lit_q + {{(CNT_W-1){1'b0}}, pix_in};
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d   = '0;
          state_d = StDrain;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (handshake) begin
      if (last_rd) begin
        rd_idx_d     = '0;
        state_d      = StCapture;
        frame_done_d = 1'b1;
        lit_d        = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCapture;
      col_q        <= '0;
      row_q        <= '0;
      rd_idx_q     <= '0;
      shift_q      <= '0;
      lit_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rd_idx_q     <= rd_idx_d;
      shift_q      <= shift_d;
      lit_q        <= lit_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Row storage needs no reset: it is only read while draining a fully written frame.
  always_ff @(posedge clk) begin
    if (!rst && accept && last_col) begin
      row_buf_q[row_q] <= row_word;
    end
  end

  always_comb begin
    out_row     = out_valid ? row_buf_q[rd_idx_q] : '0;
    out_row_idx = rd_idx_q;
    lit_count   = lit_q;
    frame_done  = frame_done_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_crt_frame_capture.sv
// Self-checking bench for crt_frame_capture: frames are drawn from a pixel-image model and
// every drained row, index, count and flag is compared against that model.
module tb_crt_frame_capture;

  localparam int W = 40;
  localparam int H = 6;
  localparam int C = 16;

  logic           clk;
  logic           rst;
  logic           pix_valid;
  logic           pix_in;
  logic           pix_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_row;
  logic [2:0]     out_row_idx;
  logic [C-1:0]   lit_count;
  logic           frame_done;
  logic           overflow;

  int tests;
  int fails;

  bit img [H][W];
  int exp_lit;

  crt_frame_capture #(
    .WIDTH  (W),
    .HEIGHT (H),
    .CNT_W  (C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_in      (pix_in),
    .pix_ready   (pix_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .lit_count   (lit_count),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Column c of a row appears at bit W-1-c.
  function automatic logic [W-1:0] exp_row(input int r);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < W; c++) v[W-1-c] = img[r][c];
    return v;
  endfunction

  task automatic fill_img(input int mode);
    exp_lit = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = ((c % 4) < 2);
          2:       img[r][c] = (c == r);
          3:       img[r][c] = 1'($urandom);
          default: img[r][c] = 1'b0;
        endcase
        exp_lit += int'(img[r][c]);
      end
    end
  endtask

  task automatic idle_cycle();
    pix_valid = 1'b0;
    pix_in    = 1'($urandom);
    @(negedge clk);
  endtask

  // gap_mode: 0 = none, 1 = valid toggles every cycle, 2 = random idle gaps
  task automatic send_frame(input int gap_mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap_mode == 2) begin
          int n;
          n = int'($urandom_range(0, 2));
          for (int k = 0; k < n; k++) idle_cycle();
        end
        pix_valid = 1'b1;
        pix_in    = img[r][c];
        if (c == 0 || (r == H - 1 && c == W - 1)) check("pix_ready_capture", 64'(pix_ready), 64'd1);
        if (c == 0) check("out_valid_capture", 64'(out_valid), 64'd0);
        @(negedge clk);
        if (gap_mode == 1 && !(r == H - 1 && c == W - 1)) idle_cycle();
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain_check(input int stall, input bit rand_ready, input bit inject);
    int r;
    int cyc;
    int st;
    r   = 0;
    cyc = 0;
    st  = stall;
    while (r < H && cyc < 400) begin
      if (st > 0) begin
        out_ready = 1'b0;
        st--;
      end else begin
        out_ready = rand_ready ? 1'($urandom) : 1'b1;
      end
      if (inject) begin
        pix_valid = 1'($urandom);
        pix_in    = 1'b1;
      end
      check("out_valid_drain", 64'(out_valid), 64'd1);
      check("out_row_idx", 64'(out_row_idx), 64'(r));
      check("out_row", 64'(out_row), 64'(exp_row(r)));
      check("lit_count_drain", 64'(lit_count), 64'(exp_lit));
      check("pix_ready_drain", 64'(pix_ready), 64'd0);
      @(negedge clk);
      if (out_ready) r++;
      cyc++;
    end
    if (r < H) check("drain_timeout", 64'(r), 64'(H));
    if (!rand_ready) check("drain_cycles", 64'(cyc), 64'(stall + H));
    out_ready = 1'b0;
    pix_valid = 1'b0;
    check("frame_done_pulse", 64'(frame_done), 64'd1);
    check("out_valid_after", 64'(out_valid), 64'd0);
    check("lit_count_cleared", 64'(lit_count), 64'd0);
    check("pix_ready_after", 64'(pix_ready), 64'd1);
    @(negedge clk);
    check("frame_done_single", 64'(frame_done), 64'd0);
  endtask

  task automatic check_reset_state();
    check("rst_pix_ready", 64'(pix_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_row", 64'(out_row), 64'd0);
    check("rst_out_row_idx", 64'(out_row_idx), 64'd0);
    check("rst_lit_count", 64'(lit_count), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    // All-lit frame, gap-free, downstream always ready
    fill_img(0);
    send_frame(0);
    drain_check(0, 1'b0, 1'b0);
    check("overflow_clean", 64'(overflow), 64'd0);

    // "##.." pattern
    fill_img(1);
    send_frame(0);
    drain_check(0, 1'b0, 1'b0);

    // Diagonal, valid toggling every cycle
    fill_img(2);
    send_frame(1);
    drain_check(0, 1'b0, 1'b0);

    // Random frame, 10-cycle downstream stall
    fill_img(3);
    send_frame(0);
    drain_check(10, 1'b0, 1'b0);

    // Random frames with random gaps and random backpressure
    for (int f = 0; f < 3; f++) begin
      fill_img(3);
      send_frame(2);
      drain_check(0, 1'b1, 1'b0);
    end

    // Pixels offered during drain are dropped and latch overflow
    fill_img(3);
    send_frame(0);
    drain_check(2, 1'b0, 1'b1);
    check("overflow_set", 64'(overflow), 64'd1);
    fill_img(3);
    send_frame(2);
    drain_check(0, 1'b1, 1'b0);
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Abort a partial frame with reset, then a clean all-zero frame
    for (int i = 0; i < 100; i++) begin
      pix_valid = 1'b1;
      pix_in    = 1'($urandom);
      @(negedge clk);
    end
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    pix_valid = 1'b0;
    check_reset_state();
    fill_img(4);
    send_frame(0);
    drain_check(0, 1'b0, 1'b0);
    check("overflow_after_rst", 64'(overflow), 64'd0);

    // Random frame right after the zero frame to expose stale row/shift state
    fill_img(3);
    send_frame(0);
    drain_check(0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
